// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: command edge detect, 5-state FSM, tick prescaler and 4-digit BCD count.
// STOPWATCH_WRAP_EN: when defined, 99.99 wraps to 00.00 instead of saturating into FIM.
module stopwatch_controller #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       resetC,
  input  logic       contarC,
  input  logic       pausarC,
  input  logic       pararC,
  output logic [3:0] num_ms,
  output logic [3:0] num_us,
  output logic [3:0] num_ds,
  output logic [3:0] num_cs,
  output logic [2:0] estado,
  output logic       rodando,
  output logic       fim
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    CONTA  = 3'd1,
    PAUSA  = 3'd2,
    PARADO = 3'd3,
    FIM    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ps_q, ps_d;
  logic [3:0][3:0] dig_q, dig_d;   // [3]=ms .. [0]=cs
  logic [3:0]      prev_q, prev_d; // {reset, parar, pausar, contar}
  logic            rodando_q, rodando_d;
  logic            fim_q, fim_d;

  logic [3:0] cmd_in, cmd_edge;
  logic       tick;

  function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] d);
    logic [3:0][3:0] r;
    logic            c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (d[i] >= 4'd9) r[i] = 4'd0;
        else begin
          r[i] = d[i] + 4'd1;
          c    = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    cmd_in    = {resetC, pararC, pausarC, contarC};
    cmd_edge  = cmd_in & ~prev_q;
    prev_d    = cmd_in;
    state_d   = state_q;
    ps_d      = ps_q;
    dig_d     = dig_q;
    fim_d     = 1'b0;
    tick      = (state_q == CONTA) && (ps_q == PS_MAX);

    // Time base runs off the current state, so a pause/stop edge still completes its tick.
    if (state_q == CONTA) begin
      if (tick) begin
        ps_d = '0;
        if (dig_q == 16'h9999) begin
`ifdef STOPWATCH_WRAP_EN
          dig_d = '0;
          fim_d = 1'b1;
`else
          state_d = FIM;
          fim_d   = 1'b1;
`endif
        end else begin
          dig_d = bcd_inc(dig_q);
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end

    // Highest-priority edge wins; an overflow into FIM outranks pause/stop.
    if (cmd_edge[3]) begin
      state_d = ZERO;
      dig_d   = '0;
      ps_d    = '0;
      fim_d   = 1'b0;
    end else if (cmd_edge[2]) begin
      if ((state_q == CONTA && state_d != FIM) || state_q == PAUSA) state_d = PARADO;
    end else if (cmd_edge[1]) begin
      if (state_q == CONTA && state_d != FIM) state_d = PAUSA;
    end else if (cmd_edge[0]) begin
      case (state_q)
        ZERO, PAUSA: state_d = CONTA;
        PARADO: begin
          state_d = CONTA;
          dig_d   = '0;
          ps_d    = '0;
        end
        default: ;
      endcase
    end

    rodando_d = (state_d == CONTA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ZERO;
      ps_q      <= '0;
      dig_q     <= '0;
      prev_q    <= 4'hF;
      rodando_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      dig_q     <= dig_d;
      prev_q    <= prev_d;
      rodando_q <= rodando_d;
      fim_q     <= fim_d;
    end
  end

  assign num_ms  = dig_q[3];
  assign num_us  = dig_q[2];
  assign num_ds  = dig_q[1];
  assign num_cs  = dig_q[0];
  assign estado  = state_q;
  assign rodando = rodando_q;
  assign fim     = fim_q;

endmodule
